// File: rtl/s1_pkg.sv
// Shared definitions for the Arduino note-channel scheduler: state codes,
// requester indices and the fixed-priority arbitration helper.
package s1_pkg;

  localparam int NOTE_W_DEF = 4;

  localparam int REQ_ERRO = 0;
  localparam int REQ_SEQ  = 1;
  localparam int REQ_BTN  = 2;
  localparam int N_REQ    = 3;

  typedef enum logic [2:0] {
    OCIOSO = 3'd0,
    ENVIA  = 3'd1,
    TOCA   = 3'd2,
    PAUSA  = 3'd3,
    FIM    = 3'd4
  } estado_t;

  // One-hot winner indexed by REQ_*; priority erro > seq > btn.
  function automatic logic [N_REQ-1:0] arbitra(input logic erro, input logic seq, input logic btn);
    logic [N_REQ-1:0] g;
    g = {N_REQ{1'b0}};
    if (erro) begin
      g[REQ_ERRO] = 1'b1;
    end else if (seq) begin
      g[REQ_SEQ] = 1'b1;
    end else if (btn) begin
      g[REQ_BTN] = 1'b1;
    end else begin
      g = {N_REQ{1'b0}};
    end
    return g;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/s1_temporizador.sv
// Loadable down-counter shared by the ack, note and gap phases.
// Saturates at zero; a load always takes precedence over counting.
module s1_temporizador
  import s1_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         carrega,
  input  logic [W-1:0] valor,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: load, decrement, or hold at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (carrega) begin
      cnt_d = valor;
    end else if (cnt_q != {W{1'b0}}) begin
      cnt_d = cnt_q - W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == {W{1'b0}});

endmodule

// File: rtl/s1_escalonador_nota.sv
// Fixed-priority arbiter/sequencer for the single Arduino note channel.
// Optional ack timeout enabled by defining S1_ACK_TIMEOUT_EN.
module s1_escalonador_nota
  import s1_pkg::*;
#(
  parameter int                NOTE_W    = NOTE_W_DEF,
  parameter int                T_NOTA    = 1000,
  parameter int                T_PAUSA   = 250,
  parameter int                T_ACK     = 5000,
  parameter logic [NOTE_W-1:0] NOTA_ERRO = 4'hF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              habilita,
  input  logic              req_seq,
  input  logic [NOTE_W-1:0] nota_seq,
  input  logic              req_btn,
  input  logic [NOTE_W-1:0] nota_btn,
  input  logic              req_erro,
  output logic              gnt_seq,
  output logic              gnt_btn,
  output logic              gnt_erro,
  output logic              ard_valid,
  output logic [NOTE_W-1:0] ard_nota,
  input  logic              ard_ack,
  output logic              muda_nota,
  output logic              falha_ack,
  output logic              ocupado,
  output logic [2:0]        db_estado
);

  localparam int TMR_MAX = max3(T_NOTA, T_PAUSA, T_ACK);
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  localparam logic [TMR_W-1:0] V_NOTA  = TMR_W'(T_NOTA - 1);
  localparam logic [TMR_W-1:0] V_PAUSA = TMR_W'(T_PAUSA - 1);
`ifdef S1_ACK_TIMEOUT_EN
  localparam logic [TMR_W-1:0] V_ENVIA = TMR_W'(T_ACK - 1);
`else
  localparam logic [TMR_W-1:0] V_ENVIA = {TMR_W{1'b0}};
`endif

  estado_t           estado_q, estado_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [NOTE_W-1:0] nota_q, nota_d;
  logic              falha_q, falha_d;
  logic              carrega_s;
  logic [TMR_W-1:0]  valor_s;
  logic              zero_s;

  s1_temporizador #(.W(TMR_W)) u_tmr (
    .clock   (clock),
    .reset   (reset),
    .carrega (carrega_s),
    .valor   (valor_s),
    .zero    (zero_s)
  );

  // State, grant and latched-note registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q <= OCIOSO;
      gnt_q    <= {N_REQ{1'b0}};
      nota_q   <= {NOTE_W{1'b0}};
      falha_q  <= 1'b0;
    end else begin
      estado_q <= estado_d;
      gnt_q    <= gnt_d;
      nota_q   <= nota_d;
      falha_q  <= falha_d;
    end
  end

  // Next state, arbitration and timer loads.
  always_comb begin
    estado_d  = estado_q;
    gnt_d     = gnt_q;
    nota_d    = nota_q;
    falha_d   = 1'b0;
    carrega_s = 1'b0;
    valor_s   = {TMR_W{1'b0}};
    // Losing the enable aborts any note silently, whatever phase it is in.
    if ((estado_q != OCIOSO) && !habilita) begin
      estado_d = OCIOSO;
      gnt_d    = {N_REQ{1'b0}};
    end else begin
      case (estado_q)
        OCIOSO: begin
          if (habilita && (req_erro || req_seq || req_btn)) begin
            gnt_d     = arbitra(req_erro, req_seq, req_btn);
            nota_d    = req_erro ? NOTA_ERRO : (req_seq ? nota_seq : nota_btn);
            carrega_s = 1'b1;
            valor_s   = V_ENVIA;
            estado_d  = ENVIA;
          end else begin
            gnt_d    = {N_REQ{1'b0}};
            estado_d = OCIOSO;
          end
        end
        ENVIA: begin
          if (ard_ack) begin
            carrega_s = 1'b1;
            valor_s   = V_NOTA;
            estado_d  = TOCA;
`ifdef S1_ACK_TIMEOUT_EN
          end else if (zero_s) begin
            gnt_d    = {N_REQ{1'b0}};
            falha_d  = 1'b1;
            estado_d = OCIOSO;
`endif
          end else begin
            estado_d = ENVIA;
          end
        end
        TOCA: begin
          if (zero_s) begin
            carrega_s = 1'b1;
            valor_s   = V_PAUSA;
            estado_d  = PAUSA;
          end else begin
            estado_d = TOCA;
          end
        end
        PAUSA: begin
          if (zero_s) begin
            estado_d = FIM;
          end else begin
            estado_d = PAUSA;
          end
        end
        FIM: begin
          gnt_d    = {N_REQ{1'b0}};
          estado_d = OCIOSO;
        end
        default: begin
          gnt_d    = {N_REQ{1'b0}};
          estado_d = OCIOSO;
        end
      endcase
    end
  end

  // Outputs decoded from registered state.
  always_comb begin
    gnt_erro  = gnt_q[REQ_ERRO];
    gnt_seq   = gnt_q[REQ_SEQ];
    gnt_btn   = gnt_q[REQ_BTN];
    ard_valid = (estado_q == ENVIA);
    ocupado   = (estado_q != OCIOSO);
    db_estado = estado_q;
    falha_ack = falha_q;
    muda_nota = (estado_q == FIM) && habilita;
    case (estado_q)
      ENVIA, TOCA, PAUSA: ard_nota = nota_q;
      default:            ard_nota = {NOTE_W{1'b0}};
    endcase
  end

endmodule

// File: tb/tb_s1_escalonador_nota.sv
// Self-checking bench for s1_escalonador_nota (T_NOTA=4, T_PAUSA=2, T_ACK=8).
// Timeout checks follow S1_ACK_TIMEOUT_EN.
module tb_s1_escalonador_nota;

  logic       clock = 1'b0;
  logic       reset;
  logic       habilita, req_seq, req_btn, req_erro, ard_ack;
  logic [3:0] nota_seq, nota_btn;
  logic       gnt_seq, gnt_btn, gnt_erro, ard_valid, muda_nota, falha_ack, ocupado;
  logic [3:0] ard_nota;
  logic [2:0] db_estado;

  int checks = 0;
  int errors = 0;

  s1_escalonador_nota #(
    .NOTE_W(4), .T_NOTA(4), .T_PAUSA(2), .T_ACK(8), .NOTA_ERRO(4'hF)
  ) dut (
    .clock(clock), .reset(reset), .habilita(habilita),
    .req_seq(req_seq), .nota_seq(nota_seq), .req_btn(req_btn), .nota_btn(nota_btn),
    .req_erro(req_erro), .gnt_seq(gnt_seq), .gnt_btn(gnt_btn), .gnt_erro(gnt_erro),
    .ard_valid(ard_valid), .ard_nota(ard_nota), .ard_ack(ard_ack),
    .muda_nota(muda_nota), .falha_ack(falha_ack), .ocupado(ocupado), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       hab, rerr, rseq, rbtn, ack;
    logic [3:0] nseq, nbtn;
    logic [2:0] e_gnt;   // {erro, seq, btn}
    logic       e_val, e_muda;
    logic [3:0] e_nota;
    logic [2:0] e_est;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Advance until muda_nota is seen; n = edges taken. Bounded.
  task automatic wait_muda(output int n);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      n++;
      if (muda_nota) break;
    end
    if (!muda_nota) begin
      errors++;
      $display("FAIL wait_muda timeout actual=0 expected=1");
    end
  endtask

  function automatic vec_t mkv(logic hab, logic rerr, logic rseq, logic rbtn, logic ack,
                               logic [2:0] g, logic v, logic [3:0] nt, logic m, logic [2:0] e);
    vec_t x;
    x.hab = hab; x.rerr = rerr; x.rseq = rseq; x.rbtn = rbtn; x.ack = ack;
    x.nseq = 4'h3; x.nbtn = 4'h9;
    x.e_gnt = g; x.e_val = v; x.e_nota = nt; x.e_muda = m; x.e_est = e;
    return x;
  endfunction

  initial begin
    int n;
    habilita = 1'b0; req_seq = 1'b0; req_btn = 1'b0; req_erro = 1'b0; ard_ack = 1'b0;
    nota_seq = 4'h0; nota_btn = 4'h0;
    reset = 1'b0;

    // Seq note with ack one cycle late, then disabled idle with a pending request.
    vecs[0]  = mkv(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 1'b1, 4'h3, 1'b0, 3'd1);
    vecs[1]  = mkv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 1'b1, 4'h3, 1'b0, 3'd1);
    vecs[2]  = mkv(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b010, 1'b0, 4'h3, 1'b0, 3'd2);
    vecs[3]  = mkv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0, 4'h3, 1'b0, 3'd2);
    vecs[4]  = mkv(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'b010, 1'b0, 4'h3, 1'b0, 3'd2);
    vecs[5]  = mkv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0, 4'h3, 1'b0, 3'd2);
    vecs[6]  = mkv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0, 4'h3, 1'b0, 3'd3);
    vecs[7]  = mkv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0, 4'h3, 1'b0, 3'd3);
    vecs[8]  = mkv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0, 4'h0, 1'b1, 3'd4);
    vecs[9]  = mkv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 4'h0, 1'b0, 3'd0);
    vecs[10] = mkv(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 4'h0, 1'b0, 3'd0);
    vecs[11] = mkv(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 4'h0, 1'b0, 3'd0);

    #1;
    chk("reset_outputs", {gnt_erro, gnt_seq, gnt_btn, ard_valid, ard_nota, muda_nota,
                          falha_ack, ocupado, db_estado}, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    tick();
    chk("post_reset_state", {29'h0, db_estado}, 32'd0);

    for (int i = 0; i < 12; i++) begin
      habilita = vecs[i].hab; req_erro = vecs[i].rerr; req_seq = vecs[i].rseq;
      req_btn = vecs[i].rbtn; ard_ack = vecs[i].ack;
      nota_seq = vecs[i].nseq; nota_btn = vecs[i].nbtn;
      tick();
      chk($sformatf("vec%0d", i),
          {gnt_erro, gnt_seq, gnt_btn, ard_valid, ard_nota, muda_nota, db_estado},
          {vecs[i].e_gnt, vecs[i].e_val, vecs[i].e_nota, vecs[i].e_muda, vecs[i].e_est});
    end

    // Three simultaneous requests, ack held high: erro, then seq, then btn.
    habilita = 1'b1; req_erro = 1'b1; req_seq = 1'b1; req_btn = 1'b1; ard_ack = 1'b1;
    nota_seq = 4'h5; nota_btn = 4'h9;
    tick();
    chk("arb_erro_grant", {gnt_erro, gnt_seq, gnt_btn, ard_nota}, {3'b100, 4'hF});
    req_erro = 1'b0;
    wait_muda(n);
    chk("arb_erro_latency", n, 32'd7);
    chk("arb_erro_fim_gnt", {gnt_erro, gnt_seq, gnt_btn}, 3'b100);
    tick();
    chk("arb_idle1", {gnt_erro, gnt_seq, gnt_btn, ocupado, db_estado}, {4'b0000, 3'd0});
    tick();
    chk("arb_seq_grant", {gnt_erro, gnt_seq, gnt_btn, ard_nota}, {3'b010, 4'h5});
    req_seq = 1'b0;
    wait_muda(n);
    chk("arb_seq_latency", n, 32'd7);
    tick();
    chk("arb_idle2", {29'h0, db_estado}, 32'd0);
    tick();
    chk("arb_btn_grant", {gnt_erro, gnt_seq, gnt_btn, ard_nota}, {3'b001, 4'h9});
    req_btn = 1'b0;
    wait_muda(n);
    chk("arb_btn_latency", n, 32'd7);
    tick();
    chk("arb_single_pulse", {31'h0, muda_nota}, 32'd0);

    // Enable dropped during PAUSA.
    req_seq = 1'b1; nota_seq = 4'h6;
    tick();
    req_seq = 1'b0;
    for (int i = 0; i < 20 && db_estado != 3'd3; i++) tick();
    chk("reach_pausa", {29'h0, db_estado}, 32'd3);
    habilita = 1'b0;
    tick();
    chk("hab_drop", {gnt_erro, gnt_seq, gnt_btn, muda_nota, db_estado}, {4'b0000, 3'd0});
    tick();
    chk("hab_drop_no_muda", {31'h0, muda_nota}, 32'd0);
    habilita = 1'b1;

    // Asynchronous reset in the middle of TOCA.
    req_btn = 1'b1;
    tick();
    req_btn = 1'b0;
    for (int i = 0; i < 20 && db_estado != 3'd2; i++) tick();
    chk("reach_toca", {29'h0, db_estado}, 32'd2);
    #2 reset = 1'b0;
    #1;
    chk("reset_mid_toca", {gnt_erro, gnt_seq, gnt_btn, ard_valid, ard_nota, muda_nota,
                           falha_ack, ocupado, db_estado}, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    tick();
    chk("reset_release", {28'h0, ocupado, db_estado}, 32'd0);

    // Ack withheld.
    ard_ack = 1'b0; req_seq = 1'b1; nota_seq = 4'h2;
    tick();
    req_seq = 1'b0;
`ifdef S1_ACK_TIMEOUT_EN
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      n++;
      if (falha_ack || muda_nota) break;
    end
    chk("timeout_latency", n, 32'd8);
    chk("timeout_pulse", {30'h0, falha_ack, muda_nota}, 32'b10);
    chk("timeout_state", {gnt_erro, gnt_seq, gnt_btn, db_estado}, {3'b000, 3'd0});
    tick();
    chk("timeout_one_cycle", {31'h0, falha_ack}, 32'd0);
`else
    n = 0;
    for (int i = 0; i < 10000; i++) begin
      tick();
      if (db_estado != 3'd1 || !ard_valid || falha_ack) n++;
    end
    chk("no_timeout_hold", n, 32'd0);
    chk("no_timeout_envia", {gnt_seq, ard_valid, ard_nota, db_estado}, {2'b11, 4'h2, 3'd1});
    ard_ack = 1'b1;
    wait_muda(n);
    chk("late_ack_latency", n, 32'd7);
    ard_ack = 1'b0;
    tick();
    chk("late_ack_idle", {29'h0, db_estado}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/s1_escalonador_nota.md
# s1_escalonador_nota

Fixed-priority arbiter and sequencer for the single note channel to the Arduino. It shares that channel between three requesters from the game control unit: sequence playback, player-button echo and the error tone. It grants one requester at a time and runs a send/ack handshake with the Arduino, then times note and gap. It returns a one-cycle `muda_nota` pulse that tells the control FSM the note has finished.

## Interface
- `NOTE_W`, 4: width of a note code.
- `T_NOTA`, 1000: note duration in clocks, ≥1.
- `T_PAUSA`, 250: silent gap after a note in clocks, ≥1.
- `T_ACK`, 5000: ack wait limit in clocks, ≥1; used only when `S1_ACK_TIMEOUT_EN` is defined.
- `NOTA_ERRO`, 4'hF: note code sent for the error tone.
- `clock`, in, 1: system clock, rising edge.
- `reset`, in, 1: asynchronous, active-low reset (asserted at 0).
- `habilita`, in, 1: channel enable, driven from `activateArduino`.
- `req_seq`, in, 1: sequence-playback request, level.
- `nota_seq`, in, NOTE_W: note code from the sequence memory.
- `req_btn`, in, 1: button-echo request, level.
- `nota_btn`, in, NOTE_W: note code of the pressed button.
- `req_erro`, in, 1: error-tone request, level.
- `gnt_seq` / `gnt_btn` / `gnt_erro`, out, 1 each: grants, one-hot or all zero.
- `ard_valid`, out, 1: note code on `ard_nota` is valid.
- `ard_nota`, out, NOTE_W: note code sent to the Arduino.
- `ard_ack`, in, 1: Arduino has accepted the note (assumed synchronous to `clock`).
- `muda_nota`, out, 1: one-cycle pulse when the granted note is complete.
- `falha_ack`, out, 1: one-cycle pulse on ack timeout. Tied to 0 when the feature is compiled out.
- `ocupado`, out, 1: high in every state except OCIOSO.
- `db_estado`, out, 3: current state code.

## Operation
- States and codes: OCIOSO=0, ENVIA=1, TOCA=2, PAUSA=3, FIM=4.
- **OCIOSO**: when `habilita`=1 and any request is high:
  - Pick the winner by priority: erro > seq > btn.
  - Latch the winner's note into `nota_reg`. The error tone uses `NOTA_ERRO`.
  - Latch the winner's grant, load the timer, go to ENVIA.
- **ENVIA**: `ard_valid`=1 and `ard_nota`=`nota_reg`.
  - `ard_ack`=1 → go to TOCA and load the timer with `T_NOTA`-1.
- **TOCA**: counts down to 0, then go to PAUSA and load the timer with `T_PAUSA`-1.
- **PAUSA**: counts down to 0, then go to FIM.
- **FIM**: assert `muda_nota` and drop the grant, then go to OCIOSO.
- Grants:
  - The grant stays high from ENVIA through FIM inclusive.
  - Arbitration is non-preemptive. Request changes after the grant are ignored until OCIOSO.
- `ard_valid` is high only in ENVIA.
  - `ard_nota` holds `nota_reg` from ENVIA through PAUSA.
  - `ard_nota` is 0 in OCIOSO and FIM.
- `habilita`=0 in any state other than OCIOSO:
  - Next state is OCIOSO and grants clear.
  - No `muda_nota` and no `falha_ack` are produced.
- Requests held high are re-arbitrated in OCIOSO. Back-to-back notes therefore cost 1 idle cycle.
- Timer:
  - Width is $clog2 of the largest of `T_NOTA`, `T_PAUSA` and `T_ACK`.
  - Unsigned, loaded with value−1, never wraps.
- Reset: state=OCIOSO and every output is 0, `db_estado` included. `nota_reg` and the timer are 0.

## Timing
- Request sampled high in OCIOSO at edge n → ENVIA, grant and `ard_valid` all high after edge n.
- Ack sampled at edge m → TOCA after m. TOCA lasts exactly `T_NOTA` cycles and PAUSA exactly `T_PAUSA` cycles.
- FIM lasts 1 cycle. `muda_nota` is high during FIM.
- Minimum request-to-`muda_nota` latency with an immediate ack: 1 (ENVIA) + `T_NOTA` + `T_PAUSA` cycles, with the pulse in the following cycle.
- Ack during TOCA, PAUSA or FIM is ignored.
- Simultaneous requests in the same cycle: priority decides. A loser keeps waiting with no error.

## Configuration
- `S1_ACK_TIMEOUT_EN` defined:
  - ENVIA loads the timer with `T_ACK`-1.
  - Timer reaching 0 with no ack → go to OCIOSO, pulse `falha_ack` for 1 cycle, no `muda_nota`.
  - Ack in the same cycle the timer reaches 0 wins (go to TOCA).
- `S1_ACK_TIMEOUT_EN` undefined: ENVIA waits for the ack indefinitely and `falha_ack`=0.

## Structure
- Shared package `s1_pkg` holds:
  - State encodings (OCIOSO..FIM).
  - Requester index constants (REQ_ERRO=0, REQ_SEQ=1, REQ_BTN=2).
  - Default note width.
- One sub-module, `s1_temporizador`: a loadable down-counter with `carrega`, `valor` and `zero` ports, shared by the ack, note and gap phases.

## Test plan
- Reset low mid-TOCA → all outputs 0 immediately, `db_estado`=0. Release → OCIOSO.
- `T_NOTA`=4, `T_PAUSA`=2, `req_seq`=1, `nota_seq`=4'h3, ack 1 cycle after `ard_valid`:
  - `ard_nota`=3 during ENVIA.
  - `muda_nota` pulses exactly 1+1+4+2 cycles after the grant, once.
- `req_erro`, `req_seq` and `req_btn` rise in the same cycle:
  - `gnt_erro` first with `ard_nota`=F.
  - Then `gnt_seq`, then `gnt_btn`, each 1 idle cycle apart.
- `habilita` dropped during PAUSA → OCIOSO next cycle, no `muda_nota`, grants 0.
- With `S1_ACK_TIMEOUT_EN` and `T_ACK`=8, ack never arrives → `falha_ack` after 8 ENVIA cycles, no `muda_nota`.
- Without the macro, ack withheld for 10000 cycles → still in ENVIA with `ard_valid`=1. Ack → normal completion.
